// File: rtl/ex_stage.sv
// Execute stage: operand-B select, single-cycle ALU, and iterative 32-bit unsigned
// multiply/divide into HI/LO with a stall request while the iteration runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [3:0]  alu_ctl,
    input  logic        ALUSrc,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] imm_ext,
    input  logic [4:0]  shamt,
    output logic [31:0] ALUout,
    output logic        zero,
    output logic        stall
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] work_q;
    logic [31:0] opb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        start;
    logic [31:0] op_b;
    logic [31:0] alu_res;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    assign is_md = (alu_ctl == OP_MULTU) || (alu_ctl == OP_DIVU);
    assign start = valid && is_md;
    assign op_b  = ALUSrc ? imm_ext : rd2;

    // Shift-add: work_q = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next = {mul_sum, work_q[31:1]};

    // Restoring divide: work_q = {partial remainder, dividend/quotient bits}.
    assign div_shift = {work_q[63:32], work_q[31]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[31:0] - opb_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), work_q[30:0], div_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            work_q  <= 64'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        work_q  <= {32'd0, rd1};
                        opb_q   <= rd2;
                        cnt_q   <= 5'd0;
                        state_q <= (alu_ctl == OP_MULTU) ? S_MUL : S_DIV;
                    end
                end
                S_MUL: begin
                    work_q <= mul_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        hi_q    <= mul_next[63:32];
                        lo_q    <= mul_next[31:0];
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    work_q <= div_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        hi_q    <= div_next[63:32];
                        lo_q    <= div_next[31:0];
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so the request drops the instant reset is asserted.
    assign stall = !rst && (((state_q == S_IDLE) && start) ||
                            (state_q == S_MUL) || (state_q == S_DIV));

    always_comb begin
        alu_res = 32'd0;
        case (alu_ctl)
            OP_AND:  alu_res = rd1 & op_b;
            OP_OR:   alu_res = rd1 | op_b;
            OP_ADD:  alu_res = rd1 + op_b;
            OP_SUB:  alu_res = rd1 - op_b;
            OP_SLT:  alu_res = {31'd0, ($signed(rd1) < $signed(op_b))};
            OP_NOR:  alu_res = ~(rd1 | op_b);
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        ALUout = 32'd0;
        if (state_q == S_IDLE) begin
            ALUout = alu_res;
        end
    end

    assign zero = (ALUout == 32'd0);

endmodule
